// File: rtl/greedy_code_builder_if.sv
// Bundle of every non-clock/reset signal of greedy_code_builder.
// The builder uses the slave view; the surrounding system (RAMs, the
// populate_candidates filter and the requester) uses the master view.
interface greedy_code_builder_if;

    // Request / status
    logic       start;
    logic [3:0] n;
    logic [3:0] min_dist;
    logic       busy;
    logic       complete;
    logic       err;
    logic [7:0] code_count;

    // Candidate RAM port owned by the builder (cand_sel = 0)
    logic       cand_sel;
    logic [7:0] cand_addr;
    logic [7:0] cand_data;
    logic       cand_wren;
    logic [7:0] cand_q;

    // Code RAM write port
    logic [7:0] code_addr;
    logic [7:0] code_data;
    logic       code_wren;

    // populate_candidates control
    logic [7:0] pc_code;
    logic [7:0] pc_base_cand;
    logic [7:0] pc_cand_len;
    logic [7:0] pc_base_next;
    logic [3:0] pc_min_dist;
    logic       pc_start;
    logic [7:0] pc_next_len;
    logic       pc_complete;

    modport slave (
        input  start, n, min_dist, cand_q, pc_next_len, pc_complete,
        output busy, complete, err, code_count,
               cand_sel, cand_addr, cand_data, cand_wren,
               code_addr, code_data, code_wren,
               pc_code, pc_base_cand, pc_cand_len, pc_base_next,
               pc_min_dist, pc_start
    );

    modport master (
        output start, n, min_dist, cand_q, pc_next_len, pc_complete,
        input  busy, complete, err, code_count,
               cand_sel, cand_addr, cand_data, cand_wren,
               code_addr, code_data, code_wren,
               pc_code, pc_base_cand, pc_cand_len, pc_base_next,
               pc_min_dist, pc_start
    );

endinterface

// File: rtl/greedy_code_builder.sv
// Greedy (lexicographic) code builder.
// Seeds candidate region A with every n-bit word, then repeatedly pops the
// lowest candidate into the code RAM and hands the rest of the list to
// populate_candidates, which copies the survivors into the other region.
// The two candidate regions ping-pong on every filter pass.
module greedy_code_builder #(
    parameter int         MAX_N    = 7,
    parameter logic [7:0] BASE_A   = 8'd0,
    parameter logic [7:0] BASE_B   = 8'd128,
    parameter int         READ_LAT = 2
) (
    input logic                  clock,
    input logic                  reset,
    greedy_code_builder_if.slave bus
);

    localparam int         LAT_W   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [3:0] MAX_N_W = 4'(MAX_N);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_PICK,
        S_RDWAIT,
        S_LATCH,
        S_FSTART,
        S_FWAIT,
        S_DONE
    } state_t;

    // Current state and registered outputs
    state_t             r_state;
    logic [3:0]         r_n;
    logic [7:0]         r_cur_base;
    logic [7:0]         r_oth_base;
    logic [8:0]         r_remain;
    logic [8:0]         r_idx;
    logic [LAT_W-1:0]   r_lat;
    logic               r_busy;
    logic               r_complete;
    logic               r_err;
    logic [7:0]         r_code_count;
    logic               r_cand_sel;
    logic [7:0]         r_cand_addr;
    logic [7:0]         r_cand_data;
    logic               r_cand_wren;
    logic [7:0]         r_code_addr;
    logic [7:0]         r_code_data;
    logic               r_code_wren;
    logic [7:0]         r_pc_code;
    logic [7:0]         r_pc_base_cand;
    logic [7:0]         r_pc_cand_len;
    logic [7:0]         r_pc_base_next;
    logic [3:0]         r_pc_min_dist;
    logic               r_pc_start;

    // Next-state values
    state_t             w_state;
    logic [3:0]         w_n;
    logic [7:0]         w_cur_base;
    logic [7:0]         w_oth_base;
    logic [8:0]         w_remain;
    logic [8:0]         w_idx;
    logic [LAT_W-1:0]   w_lat;
    logic               w_err;
    logic [7:0]         w_code_count;
    logic               w_cand_sel;
    logic [7:0]         w_cand_addr;
    logic [7:0]         w_cand_data;
    logic               w_cand_wren;
    logic [7:0]         w_code_addr;
    logic [7:0]         w_code_data;
    logic               w_code_wren;
    logic [7:0]         w_pc_code;
    logic [7:0]         w_pc_base_cand;
    logic [7:0]         w_pc_cand_len;
    logic [7:0]         w_pc_base_next;
    logic               w_pc_start;
    logic [8:0]         w_size;
    logic               w_bad_n;

    // Number of words of the latched width (2^n, exact up to 2^MAX_N)
    assign w_size  = 9'd1 << r_n;
    assign w_bad_n = (bus.n == 4'd0) || (bus.n > MAX_N_W);

    // Next-state and next-output decode
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state        = r_state;
        w_n            = r_n;
        w_cur_base     = r_cur_base;
        w_oth_base     = r_oth_base;
        w_remain       = r_remain;
        w_idx          = r_idx;
        w_lat          = r_lat;
        w_err          = r_err;
        w_code_count   = r_code_count;
        w_cand_sel     = r_cand_sel;
        w_cand_addr    = r_cand_addr;
        w_cand_data    = r_cand_data;
        w_cand_wren    = 1'b0;
        w_code_addr    = r_code_addr;
        w_code_data    = r_code_data;
        w_code_wren    = 1'b0;
        w_pc_code      = r_pc_code;
        w_pc_base_cand = r_pc_base_cand;
        w_pc_cand_len  = r_pc_cand_len;
        w_pc_base_next = r_pc_base_next;
        w_pc_start     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_code_count = 8'd0;
                    if (w_bad_n) begin
                        w_err   = 1'b1;
                        w_state = S_DONE;
                    end else begin
                        w_err      = 1'b0;
                        w_n        = bus.n;
                        w_cur_base = BASE_A;
                        w_oth_base = BASE_B;
                        w_idx      = 9'd0;
                        w_state    = S_INIT;
                    end
                end
            end

            // Seed region A with the words 0 .. 2^n-1, one per cycle
            S_INIT: begin
                w_cand_addr = BASE_A + r_idx[7:0];
                w_cand_data = r_idx[7:0];
                w_cand_wren = 1'b1;
                w_idx       = r_idx + 9'd1;
                if (r_idx == w_size - 9'd1) begin
                    w_remain = w_size;
                    w_state  = S_PICK;
                end
            end

            // The lowest surviving candidate always sits at the region base
            S_PICK: begin
                if (r_remain == 9'd0) begin
                    w_state = S_DONE;
                end else begin
                    w_cand_addr = r_cur_base;
                    w_lat       = '0;
                    w_state     = S_RDWAIT;
                end
            end

            S_RDWAIT: begin
                if (r_lat == LAT_W'(READ_LAT - 1)) begin
                    w_state = S_LATCH;
                end else begin
                    w_lat = r_lat + LAT_W'(1);
                end
            end

            S_LATCH: begin
                w_code_data  = bus.cand_q;
                w_code_addr  = r_code_count;
                w_code_wren  = 1'b1;
                w_code_count = r_code_count + 8'd1;
                // A lone candidate leaves nothing to filter
                w_state      = (r_remain == 9'd1) ? S_DONE : S_FSTART;
            end

            // Hand the rest of the list (everything after the pick) to the filter
            S_FSTART: begin
                w_pc_code      = r_code_data;
                w_pc_base_cand = r_cur_base + 8'd1;
                w_pc_cand_len  = r_remain[7:0] - 8'd1;
                w_pc_base_next = r_oth_base;
                w_cand_sel     = 1'b1;
                w_pc_start     = 1'b1;
                w_state        = S_FWAIT;
            end

            // Survivors now live in the other region; swap roles
            S_FWAIT: begin
                if (bus.pc_complete) begin
                    w_remain   = {1'b0, bus.pc_next_len};
                    w_cur_base = r_oth_base;
                    w_oth_base = r_cur_base;
                    w_cand_sel = 1'b0;
                    w_state    = S_PICK;
                end
            end

            S_DONE: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_n            <= 4'd0;
            r_cur_base     <= 8'd0;
            r_oth_base     <= 8'd0;
            r_remain       <= 9'd0;
            r_idx          <= 9'd0;
            r_lat          <= '0;
            r_busy         <= 1'b0;
            r_complete     <= 1'b0;
            r_err          <= 1'b0;
            r_code_count   <= 8'd0;
            r_cand_sel     <= 1'b0;
            r_cand_addr    <= 8'd0;
            r_cand_data    <= 8'd0;
            r_cand_wren    <= 1'b0;
            r_code_addr    <= 8'd0;
            r_code_data    <= 8'd0;
            r_code_wren    <= 1'b0;
            r_pc_code      <= 8'd0;
            r_pc_base_cand <= 8'd0;
            r_pc_cand_len  <= 8'd0;
            r_pc_base_next <= 8'd0;
            r_pc_min_dist  <= 4'd0;
            r_pc_start     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            r_state        <= w_state;
            r_n            <= w_n;
            r_cur_base     <= w_cur_base;
            r_oth_base     <= w_oth_base;
            r_remain       <= w_remain;
            r_idx          <= w_idx;
            r_lat          <= w_lat;
            r_busy         <= (w_state != S_IDLE);
            r_complete     <= (w_state == S_DONE);
            r_err          <= w_err;
            r_code_count   <= w_code_count;
            r_cand_sel     <= w_cand_sel;
            r_cand_addr    <= w_cand_addr;
            r_cand_data    <= w_cand_data;
            r_cand_wren    <= w_cand_wren;
            r_code_addr    <= w_code_addr;
            r_code_data    <= w_code_data;
            r_code_wren    <= w_code_wren;
            r_pc_code      <= w_pc_code;
            r_pc_base_cand <= w_pc_base_cand;
            r_pc_cand_len  <= w_pc_cand_len;
            r_pc_base_next <= w_pc_base_next;
            r_pc_min_dist  <= bus.min_dist;
            r_pc_start     <= w_pc_start;
        end
    end

    assign bus.busy         = r_busy;
    assign bus.complete     = r_complete;
    assign bus.err          = r_err;
    assign bus.code_count   = r_code_count;
    assign bus.cand_sel     = r_cand_sel;
    assign bus.cand_addr    = r_cand_addr;
    assign bus.cand_data    = r_cand_data;
    assign bus.cand_wren    = r_cand_wren;
    assign bus.code_addr    = r_code_addr;
    assign bus.code_data    = r_code_data;
    assign bus.code_wren    = r_code_wren;
    assign bus.pc_code      = r_pc_code;
    assign bus.pc_base_cand = r_pc_base_cand;
    assign bus.pc_cand_len  = r_pc_cand_len;
    assign bus.pc_base_next = r_pc_base_next;
    assign bus.pc_min_dist  = r_pc_min_dist;
    assign bus.pc_start     = r_pc_start;

endmodule
